dds_sweep_controller: RTL and testbench
=======================================

// Module: dds_sweep_controller
// PURPOSE
//  Sequences the phase_inc input of the phase accumulator (DDS frequency word) to produce
//  programmable frequency sweeps: single ramp, repeating sawtooth, or continuous triangle.
//  Sits between the register/config interface and the phase accumulator. Holds each
//  frequency word for a programmable dwell, then steps it toward a stop value with clamping.
// PARAMETERS
//  PHASE_WIDTH  32  width of frequency words (matches accumulator PHASE_WIDTH)
//  DWELL_WIDTH  16  width of dwell counter; each word is held cfg_dwell+1 cycles
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  cfg_valid  in   1            config beat valid
//  cfg_ready  out  1            config accepted when cfg_valid&cfg_ready; high only in IDLE
//  cfg_start  in   PHASE_WIDTH  first frequency word
//  cfg_stop   in   PHASE_WIDTH  final/turnaround frequency word
//  cfg_step   in   PHASE_WIDTH  increment applied per step (unsigned)
//  cfg_dwell  in   DWELL_WIDTH  hold count per word (0 = step every cycle)
//  cfg_mode   in   2            00 single, 01 sawtooth repeat, 10 triangle, 11 hold start
//  start      in   1            begin sweep (level sampled; acted on only in IDLE)
//  abort      in   1            stop immediately, any state
//  phase_inc  out  PHASE_WIDTH  registered frequency word to accumulator
//  busy       out  1            high in RUN_UP/RUN_DOWN
//  done       out  1            1-cycle pulse on normal single-mode completion
//  dir_down   out  1            1 while in RUN_DOWN
//  step_tick  out  1            1-cycle pulse on the cycle phase_inc changes value within a sweep
// BEHAVIOUR
//  Reset: phase_inc=0, busy=0, done=0, dir_down=0, step_tick=0, state=IDLE, cfg regs=0.
//  States: IDLE, RUN_UP, RUN_DOWN.
//  Config: captured into shadow regs on handshake in IDLE; eff_stop = max(cfg_start,cfg_stop).
//  start in IDLE (abort low): next cycle phase_inc=start_r, dwell_cnt=dwell_r, busy=1, RUN_UP.
//  RUN_*: dwell_cnt!=0 -> decrement, hold phase_inc. dwell_cnt==0 -> step event, reload dwell.
//  Up step: sum = phase_inc+step_r computed PHASE_WIDTH+1 wide; carry or sum>eff_stop -> eff_stop.
//  Down step: diff with borrow; borrow or diff<start_r -> start_r. Never wraps.
//  Step event at eff_stop in RUN_UP (after its full dwell):
//   single   -> done=1 for one cycle, busy=0, IDLE; phase_inc holds eff_stop.
//   sawtooth -> phase_inc=start_r, stay RUN_UP.
//   triangle -> RUN_DOWN, apply down step in the same event.
//  Step event at start_r in RUN_DOWN: RUN_UP, apply up step in the same event.
//  start==stop in triangle: phase_inc constant, state alternates each dwell.
//  Mode hold or step_r==0: phase_inc stays start_r until abort; done never pulses.
//  step_tick=1 only when the registered phase_inc value actually changes.
//  abort: next cycle IDLE, phase_inc=0, busy=0, dir_down=0, no done. abort beats start.
//  start while busy ignored; cfg_valid while busy not accepted (cfg_ready=0).
//  rst mid-sweep: same as reset values; cfg_ready=1 the cycle after rst deasserts.
// STRUCTURE
//  dds_defs.vh: state encodings (ST_IDLE/ST_RUN_UP/ST_RUN_DOWN), mode codes (MODE_SINGLE,
//   MODE_SAW, MODE_TRI, MODE_HOLD), shared with register map and testbench.
//  Sub-module sweep_dwell_timer: loadable down-counter, DWELL_WIDTH, outputs expire when
//   count==0; reload on expire/start. Stepper/clamp arithmetic and FSM stay in top.
// TESTING
//  1 single start=100 stop=130 step=10 dwell=2 -> phase_inc 100x3,110x3,120x3,130x3; done
//    pulses on the following cycle; busy=0; phase_inc holds 130.
//  2 triangle start=0 stop=20 step=10 dwell=0 -> 0,10,20,10,0,10,20...; dir_down=1 on the
//    two cycles after each 20.
//  3 clamp/overflow: single start=0 stop=25 step=10 -> 0,10,20,25,done; start=FFFF_FFF0
//    stop=FFFF_FFFF step=0x20 -> FFFF_FFF0,FFFF_FFFF, no wrap to 0.
//  4 sawtooth start=5 stop=7 step=1 dwell=0 -> 5,6,7,5,6,7...; step_tick on every change.
//  5 abort+start same cycle at 110 in test 1 -> IDLE next cycle, phase_inc=0, no done;
//    cfg_valid during busy -> cfg_ready=0, shadow regs unchanged.
//  6 rst asserted mid-sweep -> all outputs at reset values next cycle; cfg_ready=1 after release.

Source files
------------

// File: rtl/dds_sweep_controller_pkg.sv
// Shared definitions for the DDS frequency sweep controller.
//   sweep_state_t : controller state encoding (ST_IDLE / ST_RUN_UP / ST_RUN_DOWN)
//   MODE_*        : cfg_mode codes, also used by the register map and the bench
package dds_sweep_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } sweep_state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // A sweep only moves when the mode is not HOLD and the step is non-zero.
  function automatic logic sweep_moves(input logic [1:0] mode, input logic step_is_zero);
    return (mode != MODE_HOLD) && !step_is_zero;
  endfunction

endpackage

// File: rtl/dds_sweep_controller_dwell_timer.sv
// Loadable dwell down-counter for the sweep controller.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : force-load load_val (sweep start)
//   run       : count while a sweep is active; reloads load_val on expire
//   load_val  : dwell reload value
//   expire    : count == 0, i.e. the current word has been held its full dwell
module dds_sweep_controller_dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   run,
  input  logic [DWELL_WIDTH-1:0] load_val,
  output logic                   expire
);

  logic [DWELL_WIDTH-1:0] cnt;

  assign expire = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || (run && expire)) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= cnt - DWELL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_controller.sv
// DDS frequency sweep controller: drives phase_inc of the phase accumulator
// through single-ramp, sawtooth, triangle or hold sweeps. Each word is held
// cfg_dwell+1 cycles, then stepped toward the turnaround value with clamping.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_IDLE     | no sweep; config accepted; phase_inc holds last value
//   ST_RUN_UP   | stepping phase_inc upward toward eff_stop
//   ST_RUN_DOWN | stepping phase_inc downward toward start (triangle only)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_valid/ready   config handshake (ready only in ST_IDLE)
//   cfg_start/stop    first / turnaround frequency word
//   cfg_step          unsigned per-step increment
//   cfg_dwell         hold count per word (0 = step every cycle)
//   cfg_mode          MODE_SINGLE / MODE_SAW / MODE_TRI / MODE_HOLD
//   start, abort      begin sweep (idle only) / stop immediately (wins over start)
//   phase_inc         registered frequency word
//   busy, dir_down    in a RUN state / in ST_RUN_DOWN
//   done              one-cycle pulse at single-mode completion
//   step_tick         one-cycle pulse when a step changes phase_inc
module dds_sweep_controller
  import dds_sweep_controller_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_start,
  input  logic [PHASE_WIDTH-1:0] cfg_stop,
  input  logic [PHASE_WIDTH-1:0] cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic                   busy,
  output logic                   done,
  output logic                   dir_down,
  output logic                   step_tick
);

  sweep_state_t           state, state_nx;
  logic [PHASE_WIDTH-1:0] start_r, stop_r, step_r, eff_stop;
  logic [DWELL_WIDTH-1:0] dwell_r;
  logic [1:0]             mode_r;

  logic [PHASE_WIDTH-1:0] phase_nx;
  logic                   done_nx, tick_nx;
  logic                   timer_load, timer_run, dwell_expire;
  logic                   moves;

  logic [PHASE_WIDTH:0]   sum_ext, diff_ext;
  logic [PHASE_WIDTH-1:0] up_val, down_val;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN_UP) || (state == ST_RUN_DOWN);
  assign dir_down  = (state == ST_RUN_DOWN);

  always_ff @(posedge clk) begin
    if (rst) begin
      start_r <= '0;
      stop_r  <= '0;
      step_r  <= '0;
      dwell_r <= '0;
      mode_r  <= MODE_SINGLE;
    end else if (cfg_valid && cfg_ready) begin
      start_r <= cfg_start;
      stop_r  <= cfg_stop;
      step_r  <= cfg_step;
      dwell_r <= cfg_dwell;
      mode_r  <= cfg_mode;
    end
  end

  // A stop below start collapses the sweep onto start.
  assign eff_stop = (stop_r > start_r) ? stop_r : start_r;
  assign moves    = sweep_moves(mode_r, step_r == '0);

  // One extra bit catches carry/borrow so the word saturates instead of wrapping.
  assign sum_ext  = {1'b0, phase_inc} + {1'b0, step_r};
  assign diff_ext = {1'b0, phase_inc} - {1'b0, step_r};
  assign up_val   = (sum_ext[PHASE_WIDTH] || (sum_ext[PHASE_WIDTH-1:0] > eff_stop))
                    ? eff_stop : sum_ext[PHASE_WIDTH-1:0];
  assign down_val = (diff_ext[PHASE_WIDTH] || (diff_ext[PHASE_WIDTH-1:0] < start_r))
                    ? start_r : diff_ext[PHASE_WIDTH-1:0];

  dds_sweep_controller_dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .run      (timer_run),
    .load_val (dwell_r),
    .expire   (dwell_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase_inc <= '0;
      done      <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      state     <= state_nx;
      phase_inc <= phase_nx;
      done      <= done_nx;
      step_tick <= tick_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    phase_nx   = phase_inc;
    done_nx    = 1'b0;
    tick_nx    = 1'b0;
    timer_load = 1'b0;
    timer_run  = 1'b0;

    if (abort) begin
      state_nx = ST_IDLE;
      phase_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nx   = ST_RUN_UP;
            phase_nx   = start_r;
            timer_load = 1'b1;
          end
        end
        ST_RUN_UP: begin
          timer_run = 1'b1;
          if (dwell_expire && moves) begin
            if (phase_inc == eff_stop) begin
              case (mode_r)
                MODE_SINGLE: begin
                  state_nx = ST_IDLE;
                  done_nx  = 1'b1;
                end
                MODE_SAW: phase_nx = start_r;
                MODE_TRI: begin
                  state_nx = ST_RUN_DOWN;
                  phase_nx = down_val;
                end
                default: phase_nx = phase_inc;
              endcase
            end else begin
              phase_nx = up_val;
            end
          end
        end
        ST_RUN_DOWN: begin
          timer_run = 1'b1;
          if (dwell_expire && moves) begin
            if (phase_inc == start_r) begin
              state_nx = ST_RUN_UP;
              phase_nx = up_val;
            end else begin
              phase_nx = down_val;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          phase_nx = '0;
        end
      endcase
      tick_nx = timer_run && (phase_nx != phase_inc);
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: directed vector table, hand-written
// abort/config/reset sequences, and randomized sweeps against a word-list model.
module tb_dds_sweep_controller;
  import dds_sweep_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] phase_inc;
  logic        busy, done, dir_down, step_tick;

  int n_pass = 0;
  int n_total = 0;

  dds_sweep_controller #(.PHASE_WIDTH(32), .DWELL_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .start(start), .abort(abort),
    .phase_inc(phase_inc), .busy(busy), .done(done),
    .dir_down(dir_down), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  // {phase_inc, busy, dir_down, step_tick, done}
  function automatic logic [35:0] snap();
    return {phase_inc, busy, dir_down, step_tick, done};
  endfunction

  function automatic logic [35:0] pk(input longint ph, input bit b, input bit d,
                                    input bit t, input bit dn);
    logic [31:0] p;
    p = ph[31:0];
    return {p, b, d, t, dn};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                        input logic [15:0] dw, input logic [1:0] m, input string nm);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = m;
    cfg_valid = 1'b1;
    #1;
    check({nm, " cfg_ready"}, 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Walks the sweep as a list of words (each held dwell+1 cycles) using plain
  // wide integer arithmetic, producing the expected output per cycle.
  logic [35:0] exp_q[$];

  task automatic build_model(input longint s, input longint stp, input longint st,
                             input int dwell, input logic [1:0] m, input int ncyc);
    longint e, w, prev;
    bit dn, first, fin;
    e = (stp > s) ? stp : s;
    w = s; dn = 0; first = 1; fin = 0; prev = -1;
    exp_q.delete();
    while (exp_q.size() < ncyc) begin
      if (fin) begin
        exp_q.push_back(pk(e, 0, 0, 0, 0));
      end else begin
        for (int h = 0; h <= dwell; h++)
          exp_q.push_back(pk(w, 1, dn, (h == 0) && !first && (w != prev), 0));
        prev = w; first = 0;
        if (m != MODE_HOLD && st != 0) begin
          if (!dn) begin
            if (w == e) begin
              if (m == MODE_SINGLE) begin
                exp_q.push_back(pk(e, 0, 0, 0, 1));
                fin = 1;
              end else if (m == MODE_SAW) begin
                w = s;
              end else begin
                dn = 1;
                w = (w - st < s) ? s : w - st;
              end
            end else begin
              w = (w + st > e) ? e : w + st;
            end
          end else begin
            if (w == s) begin
              dn = 0;
              w = (w + st > e) ? e : w + st;
            end else begin
              w = (w - st < s) ? s : w - st;
            end
          end
        end
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string             name;
    logic [31:0]       s, e, st;
    logic [15:0]       dwell;
    logic [1:0]        mode;
    int                nw;
    logic [0:7][31:0]  words;
    logic [0:7]        dirs;
    bit                exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    logic [35:0] ex;
    bit tk;
    do_cfg(v.s, v.e, v.st, v.dwell, v.mode, v.name);
    pulse_start();
    for (int w = 0; w < v.nw; w++) begin
      for (int h = 0; h <= int'(v.dwell); h++) begin
        @(negedge clk);
        tk = (h == 0) && (w > 0) && (v.words[w] != v.words[w-1]);
        ex = {v.words[w], 1'b1, v.dirs[w], tk, 1'b0};
        check($sformatf("%s word%0d cyc%0d", v.name, w, h), 64'(snap()), 64'(ex));
      end
    end
    if (v.exp_done) begin
      @(negedge clk);
      check({v.name, " done pulse"}, 64'(snap()), 64'({v.words[v.nw-1], 4'b0001}));
      @(negedge clk);
      check({v.name, " after done"}, 64'(snap()), 64'({v.words[v.nw-1], 4'b0000}));
    end
    pulse_abort();
  endtask

  initial begin
    logic [35:0] act;
    longint rs, re, rst_v;
    int rdw, rbad;
    logic [1:0] rm;

    vecs[0] = '{"single", 32'd100, 32'd130, 32'd10, 16'd2, MODE_SINGLE, 4,
                {32'd100, 32'd110, 32'd120, 32'd130, 32'd0, 32'd0, 32'd0, 32'd0}, 8'b0, 1'b1};
    vecs[1] = '{"triangle", 32'd0, 32'd20, 32'd10, 16'd0, MODE_TRI, 7,
                {32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20, 32'd0}, 8'b00011000, 1'b0};
    vecs[2] = '{"clamp", 32'd0, 32'd25, 32'd10, 16'd0, MODE_SINGLE, 4,
                {32'd0, 32'd10, 32'd20, 32'd25, 32'd0, 32'd0, 32'd0, 32'd0}, 8'b0, 1'b1};
    vecs[3] = '{"overflow", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, MODE_SINGLE, 2,
                {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 8'b0, 1'b1};
    vecs[4] = '{"sawtooth", 32'd5, 32'd7, 32'd1, 16'd0, MODE_SAW, 7,
                {32'd5, 32'd6, 32'd7, 32'd5, 32'd6, 32'd7, 32'd5, 32'd0}, 8'b0, 1'b0};
    vecs[5] = '{"hold", 32'd50, 32'd90, 32'd5, 16'd1, MODE_HOLD, 3,
                {32'd50, 32'd50, 32'd50, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 8'b0, 1'b0};
    vecs[6] = '{"tri_equal", 32'd40, 32'd40, 32'd3, 16'd1, MODE_TRI, 4,
                {32'd40, 32'd40, 32'd40, 32'd40, 32'd0, 32'd0, 32'd0, 32'd0}, 8'b01010000, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 64'(snap()), 64'(pk(0, 0, 0, 0, 0)));
    check("reset cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // abort + start together while busy at word 110
    do_cfg(32'd100, 32'd130, 32'd10, 16'd2, MODE_SINGLE, "abort_seq");
    pulse_start();
    repeat (4) @(negedge clk);
    check("abort_seq at 110", 64'(phase_inc), 64'd110);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_seq outputs", 64'(snap()), 64'(pk(0, 0, 0, 0, 0)));
    rbad = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy || phase_inc != 0) rbad++;
    end
    check("abort_seq stays idle", 64'(rbad), 64'd0);

    // abort + start together in idle: abort wins
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort beats start idle", 64'(snap()), 64'(pk(0, 0, 0, 0, 0)));

    // config during busy is refused and shadow regs keep old values
    pulse_start();
    @(negedge clk);
    cfg_start = 32'd777; cfg_stop = 32'd900; cfg_step = 32'd3; cfg_dwell = 16'd0;
    cfg_mode = MODE_TRI; cfg_valid = 1'b1;
    #1;
    check("cfg_ready while busy", 64'(cfg_ready), 64'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    pulse_abort();
    pulse_start();
    @(negedge clk);
    check("shadow start kept", 64'(snap()), 64'(pk(100, 1, 0, 0, 0)));
    repeat (3) @(negedge clk);
    check("shadow step/dwell kept", 64'(snap()), 64'(pk(110, 1, 0, 1, 0)));
    pulse_abort();

    // reset mid-sweep
    do_cfg(32'd0, 32'd20, 32'd10, 16'd0, MODE_TRI, "rst_seq");
    pulse_start();
    repeat (4) @(negedge clk);
    check("rst_seq running down", 64'(snap()), 64'(pk(10, 1, 1, 1, 0)));
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq outputs", 64'(snap()), 64'(pk(0, 0, 0, 0, 0)));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_seq cfg_ready after release", 64'(cfg_ready), 64'd1);
    pulse_start();
    @(negedge clk);
    check("rst_seq shadow cleared", 64'(snap()), 64'(pk(0, 1, 0, 0, 0)));
    repeat (3) @(negedge clk);
    check("rst_seq zero step holds", 64'(snap()), 64'(pk(0, 1, 0, 0, 0)));
    pulse_abort();

    // randomized sweeps against the model
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) rs = 64'hFFFF_FFFF - longint'($urandom_range(0, 50));
      else rs = longint'($urandom_range(0, 100));
      re = longint'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) re = (rs - re < 0) ? 0 : rs - re;
      else re = (rs + re > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : rs + re;
      rst_v = ($urandom_range(0, 5) == 0) ? 0 : longint'($urandom_range(1, 12));
      if ($urandom_range(0, 7) == 0) rst_v = 64'h8000_0000;
      rdw = $urandom_range(0, 3);
      rm = 2'($urandom_range(0, 3));
      build_model(rs, re, rst_v, rdw, rm, 40);
      do_cfg(rs[31:0], re[31:0], rst_v[31:0], 16'(rdw), rm, $sformatf("rand%0d", i));
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        act = snap();
        check($sformatf("rand%0d mode%0d cyc%0d", i, rm, c), 64'(act), 64'(exp_q[c]));
      end
      pulse_abort();
      @(negedge clk);
      check($sformatf("rand%0d abort", i), 64'(snap()), 64'(pk(0, 0, 0, 0, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
